char_map_writer: RTL and testbench

- Write-side counterpart of the pixel-to-address path. It accepts a stream of character codes over a valid/ready handshake and maintains a text cursor (column, row).
- Produces character-map write strobes using the same linear mapping the display read path uses: addr = row*80 + col.
- Handles CR, LF, backspace, automatic line wrap, clear-on-new-line and full-screen clear.
- Sits between the bus/host text port and the character-map RAM write port.

---
 rtl/char_map_writer_pkg.sv | 28 ++
 rtl/char_map_writer_if.sv | 26 ++
 rtl/char_map_writer_cursor.sv | 48 ++++
 rtl/char_map_writer.sv | 136 +++++++++++++
 tb/tb_char_map_writer.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/char_map_writer_pkg.sv
// Shared character-map geometry, control codes and writer FSM states.
package char_map_writer_pkg;

  localparam int CH_MAP_ADDR_WIDTH = 12;
  localparam int CH_H_WIDTH        = 7;
  localparam int CH_V_WIDTH        = 5;
  localparam int CH_DATA_W         = 8;

  localparam int CH_COLS  = 80;
  localparam int CH_ROWS  = 30;
  localparam int CH_CELLS = CH_COLS * CH_ROWS;

  localparam logic [CH_DATA_W-1:0] CH_FILL  = 8'h20;
  localparam logic [CH_DATA_W-1:0] ASCII_LF = 8'h0A;
  localparam logic [CH_DATA_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [CH_DATA_W-1:0] ASCII_BS = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR_LINE,
    ST_CLR_SCREEN
  } char_map_writer_state_e;

  function automatic logic is_printable(input logic [CH_DATA_W-1:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/char_map_writer_if.sv
// Host character port plus character-map write port of the text writer.
interface char_map_writer_if;
  import char_map_writer_pkg::*;

  logic                         ch_valid_i;
  logic                         ch_ready_o;
  logic [CH_DATA_W-1:0]         ch_data_i;
  logic                         clear_i;
  logic                         we_o;
  logic [CH_MAP_ADDR_WIDTH-1:0] waddr_o;
  logic [CH_DATA_W-1:0]         wdata_o;
  logic [CH_H_WIDTH-1:0]        cursor_col_o;
  logic [CH_V_WIDTH-1:0]        cursor_row_o;
  logic                         busy_o;

  modport slave (
    input  ch_valid_i, ch_data_i, clear_i,
    output ch_ready_o, we_o, waddr_o, wdata_o, cursor_col_o, cursor_row_o, busy_o
  );

  modport master (
    output ch_valid_i, ch_data_i, clear_i,
    input  ch_ready_o, we_o, waddr_o, wdata_o, cursor_col_o, cursor_row_o, busy_o
  );

endinterface

// File: rtl/char_map_writer_cursor.sv
// Text cursor (col,row) with wrap, plus its linear cell address row*80+col.
// Controls take effect at the next clock edge; home has priority over the rest.
module char_cursor
  import char_map_writer_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         inc,
  input  logic                         cr,
  input  logic                         bs,
  input  logic                         lf,
  input  logic                         home,
  output logic [CH_H_WIDTH-1:0]        col,
  output logic [CH_V_WIDTH-1:0]        row,
  output logic                         eol,
  output logic [CH_MAP_ADDR_WIDTH-1:0] addr
);

  logic [CH_V_WIDTH-1:0]        row_next;
  logic [CH_MAP_ADDR_WIDTH-1:0] row_ext;

  assign eol      = (col == CH_H_WIDTH'(CH_COLS - 1));
  assign row_next = (row == CH_V_WIDTH'(CH_ROWS - 1)) ? '0 : row + 1'b1;

  // row*80 as two shifts so the read and write paths map identically
  assign row_ext = CH_MAP_ADDR_WIDTH'(row);
  assign addr    = (row_ext << 6) + (row_ext << 4) + CH_MAP_ADDR_WIDTH'(col);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else if (lf || (inc && eol)) begin
      col <= '0;
      row <= row_next;
    end else if (inc) begin
      col <= col + 1'b1;
    end else if (cr) begin
      col <= '0;
    end else if (bs && (col != '0)) begin
      col <= col - 1'b1;
    end
  end

endmodule

// File: rtl/char_map_writer.sv
// Character stream to character-map writer with cursor, line clear and screen clear.
// Writes appear one cycle after acceptance; ready drops for the whole of any clear sequence.
module char_map_writer
  import char_map_writer_pkg::*;
#(
  parameter logic [CH_DATA_W-1:0] FILL_CHAR = CH_FILL
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  char_map_writer_if.slave bus
);

  char_map_writer_state_e       state, state_nxt;
  logic [CH_MAP_ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                         wr_en;
  logic [CH_MAP_ADDR_WIDTH-1:0] wr_addr;
  logic [CH_DATA_W-1:0]         wr_data;
  logic                         we_q;
  logic [CH_MAP_ADDR_WIDTH-1:0] waddr_q;
  logic [CH_DATA_W-1:0]         wdata_q;
  logic                         ready, accept;
  logic                         cur_inc, cur_cr, cur_bs, cur_lf, cur_home, cur_eol;
  logic [CH_MAP_ADDR_WIDTH-1:0] cur_addr;
  logic [CH_H_WIDTH-1:0]        cur_col;
  logic [CH_V_WIDTH-1:0]        cur_row;

  char_cursor u_cursor (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .inc    (cur_inc),
    .cr     (cur_cr),
    .bs     (cur_bs),
    .lf     (cur_lf),
    .home   (cur_home),
    .col    (cur_col),
    .row    (cur_row),
    .eol    (cur_eol),
    .addr   (cur_addr)
  );

  assign ready  = (state == ST_IDLE);
  assign accept = bus.ch_valid_i & ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_addr   = cur_addr;
    wr_data   = bus.ch_data_i;
    cur_inc   = 1'b0;
    cur_cr    = 1'b0;
    cur_bs    = 1'b0;
    cur_lf    = 1'b0;
    cur_home  = 1'b0;
    // A screen clear overrides everything, including a character accepted this cycle
    if (bus.clear_i) begin
      state_nxt = ST_CLR_SCREEN;
      cnt_nxt   = '0;
      cur_home  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_printable(bus.ch_data_i)) begin
              wr_en   = 1'b1;
              cur_inc = 1'b1;
              if (cur_eol) begin
                state_nxt = ST_CLR_LINE;
                cnt_nxt   = '0;
              end
            end else if (bus.ch_data_i == ASCII_LF) begin
              cur_lf    = 1'b1;
              state_nxt = ST_CLR_LINE;
              cnt_nxt   = '0;
            end else if (bus.ch_data_i == ASCII_CR) begin
              cur_cr = 1'b1;
            end else if (bus.ch_data_i == ASCII_BS) begin
              cur_bs = 1'b1;
            end
          end
        end
        ST_CLR_LINE: begin
          // cursor already sits at column 0 of the new row, so cur_addr is the row base
          wr_en   = 1'b1;
          wr_addr = cur_addr + cnt;
          wr_data = FILL_CHAR;
          if (cnt == CH_MAP_ADDR_WIDTH'(CH_COLS - 1)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        ST_CLR_SCREEN: begin
          wr_en   = 1'b1;
          wr_addr = cnt;
          wr_data = FILL_CHAR;
          if (cnt == CH_MAP_ADDR_WIDTH'(CH_CELLS - 1)) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      we_q  <= wr_en;
      if (wr_en) begin
        waddr_q <= wr_addr;
        wdata_q <= wr_data;
      end
    end
  end

  assign bus.ch_ready_o   = ready;
  assign bus.busy_o       = ~ready;
  assign bus.we_o         = we_q;
  assign bus.waddr_o      = waddr_q;
  assign bus.wdata_o      = wdata_q;
  assign bus.cursor_col_o = cur_col;
  assign bus.cursor_row_o = cur_row;

endmodule

// File: tb/tb_char_map_writer.sv
// Bench for char_map_writer: directed scenarios plus random text checked against a cursor/screen model.
module tb_char_map_writer;
  import char_map_writer_pkg::*;

  logic clk_i   = 1'b0;
  logic arstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  char_map_writer_if bus ();

  char_map_writer dut (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [19:0] obs_q[$];
  logic [19:0] exp_q[$];
  int m_col, m_row;
  bit m_adv;

  always @(negedge clk_i)
    if (arstn_i && bus.we_o === 1'b1) obs_q.push_back({bus.waddr_o, bus.wdata_o});

  // reference model: screen is 30 rows of 80 cells, address row*80+col
  function automatic void m_adv_row();
    m_col = 0;
    m_row = (m_row + 1) % 30;
    m_adv = 1'b1;
    for (int i = 0; i < 80; i++) exp_q.push_back({12'(m_row * 80 + i), 8'h20});
  endfunction

  function automatic void m_char(input logic [7:0] c);
    m_adv = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back({12'(m_row * 80 + m_col), c});
      m_col++;
      if (m_col == 80) m_adv_row();
    end else if (c == 8'h0A) m_adv_row();
    else if (c == 8'h0D) m_col = 0;
    else if (c == 8'h08) begin
      if (m_col > 0) m_col--;
    end
  endfunction

  function automatic int stream_diff();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic logic [19:0] obs_at(input int i);
    return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 20'bx;
  endfunction

  function automatic logic [19:0] exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 20'bx;
  endfunction

  task automatic do_reset();
    bus.ch_valid_i = 1'b0;
    bus.ch_data_i  = '0;
    bus.clear_i    = 1'b0;
    @(negedge clk_i);
    arstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
    @(negedge clk_i);
    obs_q.delete();
    exp_q.delete();
    m_col = 0;
    m_row = 0;
  endtask

  task automatic send_char(input logic [7:0] c);
    bus.ch_valid_i = 1'b1;
    bus.ch_data_i  = c;
    @(negedge clk_i);
    bus.ch_valid_i = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy_o === 1'b1 && n < 6000) begin
      n++;
      @(negedge clk_i);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.we_o, bus.waddr_o, bus.wdata_o} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_write_port: got we=%b addr=%0d data=%h, want 0/0/00", bus.we_o, bus.waddr_o, bus.wdata_o);
    end
    vectors++;
    if ({bus.cursor_col_o, bus.cursor_row_o} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_cursor: got (%0d,%0d), want (0,0)", bus.cursor_col_o, bus.cursor_row_o);
    end
    vectors++;
    if ({bus.busy_o, bus.ch_ready_o} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_state: got busy=%b ready=%b, want busy=0 ready=1", bus.busy_o, bus.ch_ready_o);
    end
  endtask

  task automatic test_first_char();
    int n, d;
    do_reset();
    send_char(8'h41);
    m_char(8'h41);
    vectors++;
    if ({bus.we_o, bus.waddr_o, bus.wdata_o} !== {1'b1, 12'd0, 8'h41}) begin
      miscompares++;
      $display("FAIL first_char_write: got we=%b addr=%0d data=%h, want 1/0/41", bus.we_o, bus.waddr_o, bus.wdata_o);
    end
    wait_idle(n);
    d = stream_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL first_char_stream: at %0d got %h want %h", d, obs_at(d), exp_at(d));
    end
    vectors++;
    if ({bus.cursor_col_o, bus.cursor_row_o, bus.ch_ready_o} !== {7'd1, 5'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL first_char_cursor: got (%0d,%0d) ready=%b, want (1,0) ready=1", bus.cursor_col_o, bus.cursor_row_o, bus.ch_ready_o);
    end
  endtask

  task automatic test_lf_sequence();
    logic [7:0] seq [8] = '{8'h0A, 8'h0A, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h42};
    int n, d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_char(seq[i]);
      m_char(seq[i]);
      wait_idle(n);
      vectors++;
      if (n != (i < 2 ? 80 : 0)) begin
        miscompares++;
        $display("FAIL lf_busy_cycles[%0d]: got %0d want %0d", i, n, (i < 2 ? 80 : 0));
      end
    end
    vectors++;
    if (obs_at(obs_q.size() - 1) !== {12'd165, 8'h42}) begin
      miscompares++;
      $display("FAIL lf_b_position: got %h want %h", obs_at(obs_q.size() - 1), {12'd165, 8'h42});
    end
    send_char(8'h0D);
    m_char(8'h0D);
    wait_idle(n);
    send_char(8'h08);
    m_char(8'h08);
    wait_idle(n);
    vectors++;
    if ({bus.cursor_col_o, bus.cursor_row_o} !== {7'd0, 5'd2}) begin
      miscompares++;
      $display("FAIL cr_bs_cursor: got (%0d,%0d) want (0,2)", bus.cursor_col_o, bus.cursor_row_o);
    end
    d = stream_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL lf_stream: at %0d got %h want %h", d, obs_at(d), exp_at(d));
    end
  endtask

  task automatic test_line_wrap();
    int n, d;
    logic [7:0] c;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      c = 8'($urandom_range(32, 126));
      send_char(c);
      m_char(c);
      if (i < 79) wait_idle(n);
    end
    wait_idle(n);
    vectors++;
    if (n != 80) begin
      miscompares++;
      $display("FAIL wrap_busy_cycles: got %0d want 80", n);
    end
    vectors++;
    if (obs_at(79) !== exp_at(79) || obs_at(79) >> 8 !== 20'd79) begin
      miscompares++;
      $display("FAIL wrap_last_char: got %h want %h", obs_at(79), exp_at(79));
    end
    vectors++;
    if ({bus.cursor_col_o, bus.cursor_row_o} !== {7'd0, 5'd1}) begin
      miscompares++;
      $display("FAIL wrap_cursor: got (%0d,%0d) want (0,1)", bus.cursor_col_o, bus.cursor_row_o);
    end
    d = stream_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL wrap_stream: at %0d got %h want %h", d, obs_at(d), exp_at(d));
    end
  endtask

  task automatic test_row_wrap();
    int n, d;
    do_reset();
    repeat (29) begin
      send_char(8'h0A);
      m_char(8'h0A);
      wait_idle(n);
    end
    vectors++;
    if (bus.cursor_row_o !== 5'd29) begin
      miscompares++;
      $display("FAIL row_before_wrap: got %0d want 29", bus.cursor_row_o);
    end
    send_char(8'h0A);
    m_char(8'h0A);
    wait_idle(n);
    vectors++;
    if ({bus.cursor_col_o, bus.cursor_row_o} !== 12'h0 || obs_at(obs_q.size() - 80) !== {12'd0, 8'h20}) begin
      miscompares++;
      $display("FAIL row_wrap: got (%0d,%0d) first fill %h, want (0,0) fill 00020", bus.cursor_col_o, bus.cursor_row_o, obs_at(obs_q.size() - 80));
    end
    d = stream_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL row_wrap_stream: at %0d got %h want %h", d, obs_at(d), exp_at(d));
    end
  endtask

  task automatic test_clear();
    int n, d;
    do_reset();
    send_char(8'h0A);
    for (int i = 0; i < 10; i++) exp_q.push_back({12'(80 + i), 8'h20});
    for (int i = 0; i < 1000; i++) exp_q.push_back({12'(i), 8'h20});
    for (int i = 0; i < 2400; i++) exp_q.push_back({12'(i), 8'h20});
    repeat (10) @(negedge clk_i);
    bus.clear_i = 1'b1;
    @(negedge clk_i);
    bus.clear_i = 1'b0;
    vectors++;
    if ({bus.cursor_col_o, bus.cursor_row_o, bus.busy_o, bus.ch_ready_o} !== {12'h0, 2'b10}) begin
      miscompares++;
      $display("FAIL clear_entry: got (%0d,%0d) busy=%b ready=%b, want (0,0) busy=1 ready=0", bus.cursor_col_o, bus.cursor_row_o, bus.busy_o, bus.ch_ready_o);
    end
    repeat (1000) @(negedge clk_i);
    bus.clear_i = 1'b1;
    @(negedge clk_i);
    bus.clear_i = 1'b0;
    wait_idle(n);
    d = stream_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL clear_stream: at %0d got %h want %h (sizes %0d/%0d)", d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    end
    vectors++;
    if ({bus.cursor_col_o, bus.cursor_row_o, bus.ch_ready_o} !== {12'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL clear_done: got (%0d,%0d) ready=%b, want (0,0) ready=1", bus.cursor_col_o, bus.cursor_row_o, bus.ch_ready_o);
    end
  endtask

  task automatic test_clear_collision();
    int n, d;
    do_reset();
    send_char(8'h41);
    m_char(8'h41);
    wait_idle(n);
    bus.ch_valid_i = 1'b1;
    bus.ch_data_i  = 8'h5A;
    bus.clear_i    = 1'b1;
    @(negedge clk_i);
    bus.ch_valid_i = 1'b0;
    bus.clear_i    = 1'b0;
    for (int i = 0; i < 2400; i++) exp_q.push_back({12'(i), 8'h20});
    wait_idle(n);
    d = stream_diff();
    vectors++;
    if (d != -1) begin
      miscompares++;
      $display("FAIL collision_stream: at %0d got %h want %h (sizes %0d/%0d)", d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
    end
    vectors++;
    if ({bus.cursor_col_o, bus.cursor_row_o} !== 12'h0) begin
      miscompares++;
      $display("FAIL collision_cursor: got (%0d,%0d) want (0,0)", bus.cursor_col_o, bus.cursor_row_o);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    bus.clear_i = 1'b1;
    @(negedge clk_i);
    bus.clear_i = 1'b0;
    repeat (100) @(negedge clk_i);
    #1 arstn_i = 1'b0;
    #1;
    vectors++;
    if ({bus.we_o, bus.cursor_col_o, bus.cursor_row_o, bus.busy_o} !== 14'h0) begin
      miscompares++;
      $display("FAIL async_reset: got we=%b (%0d,%0d) busy=%b, want we=0 (0,0) busy=0", bus.we_o, bus.cursor_col_o, bus.cursor_row_o, bus.busy_o);
    end
    @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    vectors++;
    if ({bus.ch_ready_o, bus.busy_o, bus.we_o} !== 3'b100) begin
      miscompares++;
      $display("FAIL after_reset_idle: got ready=%b busy=%b we=%b, want 1/0/0", bus.ch_ready_o, bus.busy_o, bus.we_o);
    end
    obs_q.delete();
  endtask

  task automatic test_random();
    int n, d;
    int r;
    logic [7:0] c;
    logic [7:0] junk [4] = '{8'h00, 8'h1B, 8'h7F, 8'hFF};
    do_reset();
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      case (r)
        0:       c = 8'h0A;
        1:       c = 8'h0D;
        2, 3:    c = 8'h08;
        4:       c = junk[$urandom_range(0, 3)];
        default: c = 8'($urandom_range(32, 126));
      endcase
      send_char(c);
      m_char(c);
      wait_idle(n);
      d = stream_diff();
      vectors++;
      if (d != -1 || n != (m_adv ? 80 : 0)) begin
        miscompares++;
        $display("FAIL random_stream[%0d] code %h: at %0d got %h want %h, busy %0d want %0d", i, c, d, obs_at(d), exp_at(d), n, (m_adv ? 80 : 0));
      end
      vectors++;
      if ({bus.cursor_col_o, bus.cursor_row_o} !== {7'(m_col), 5'(m_row)}) begin
        miscompares++;
        $display("FAIL random_cursor[%0d] code %h: got (%0d,%0d) want (%0d,%0d)", i, c, bus.cursor_col_o, bus.cursor_row_o, m_col, m_row);
      end
    end
  endtask

  initial begin
    bus.ch_valid_i = 1'b0;
    bus.ch_data_i  = '0;
    bus.clear_i    = 1'b0;
    test_reset();
    test_first_char();
    test_lf_sequence();
    test_line_wrap();
    test_row_wrap();
    test_clear();
    test_clear_collision();
    test_reset_mid_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
